// File: rtl/pipe_adder_pkg.sv
// Shared types for the pipelined add/subtract block: operation and control-state enums.
package pipe_adder_pkg;

    typedef enum logic {
        OP_ADD = 1'b0,
        OP_SUB = 1'b1
    } op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

endpackage

// File: rtl/pipe_adder_fifo.sv
// Synchronous result FIFO for pipe_adder; storage is deliberately left unreset.
module pipe_adder_fifo #(
    parameter int unsigned WIDTH = 34,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]    count_q, count_d;
    logic             full;
    logic             push_en, pop_en;

    assign empty   = (count_q == '0);
    assign full    = (count_q == CW'(DEPTH));
    assign push_en = push && !full;
    assign pop_en  = pop && !empty;
    assign count   = count_q;
    assign pop_data = mem[rd_ptr_q];

    always_comb begin
        count_d = count_q;
        if (push_en && !pop_en) begin
            count_d = count_q + CW'(1);
        end else if (pop_en && !push_en) begin
            count_d = count_q - CW'(1);
        end
    end

    // Pointers are AW bits wide so they wrap modulo DEPTH for free.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_en) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop_en)  rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_en) begin
            mem[wr_ptr_q] <= push_data;
        end
    end

endmodule

// File: rtl/pipe_adder.sv
// Pipelined add/subtract with one stage register feeding a result FIFO.
// Optional signed saturation is enabled by defining PIPE_ADDER_SAT_EN.
module pipe_adder
    import pipe_adder_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic [WIDTH-1:0]       in_a,
    input  logic [WIDTH-1:0]       in_b,
    input  logic                   in_op,
    input  logic                   in_valid,
`ifdef PIPE_ADDER_SAT_EN
    input  logic                   in_sat,
`endif
    output logic                   in_ready,
    output logic [WIDTH-1:0]       out_sum,
    output logic                   out_carry,
    output logic                   out_ovf,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [$clog2(DEPTH):0] count
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;
    localparam int unsigned RW = WIDTH + 2;

    state_e state_q, state_d;

    logic            accept;
    op_e             op;
    logic [WIDTH-1:0] b_eff;
    logic [WIDTH:0]  raw;
    logic            ovf;
    logic [WIDTH-1:0] sum;

    logic            stage_valid_q;
    logic [RW-1:0]   stage_data_q;

    logic [RW-1:0]   fifo_data;
    logic            fifo_empty;
    logic [CW-1:0]   fifo_count;

    // Control FSM: state register, next state, outputs.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: state_d = ST_RUN;
            ST_RUN:  state_d = ST_RUN;
        endcase
    end

    // count covers the stage register too, so an accepted op always finds FIFO room.
    always_comb begin
        in_ready = (state_q == ST_RUN) && (count < CW'(DEPTH));
    end

    assign accept = in_valid && in_ready;

    // Subtract as a + ~b + 1; carry then reads as no-borrow.
    always_comb begin
        op    = op_e'(in_op);
        b_eff = (op == OP_SUB) ? ~in_b : in_b;
        raw   = {1'b0, in_a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, in_op};
        ovf   = (in_a[WIDTH-1] == b_eff[WIDTH-1]) && (raw[WIDTH-1] != in_a[WIDTH-1]);
        sum   = raw[WIDTH-1:0];
`ifdef PIPE_ADDER_SAT_EN
        if (in_sat && ovf) begin
            sum = in_a[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            stage_valid_q <= 1'b0;
            stage_data_q  <= '0;
        end else begin
            stage_valid_q <= accept;
            if (accept) begin
                stage_data_q <= {ovf, raw[WIDTH], sum};
            end
        end
    end

    pipe_adder_fifo #(
        .WIDTH (RW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .resetn    (resetn),
        .push      (stage_valid_q),
        .push_data (stage_data_q),
        .pop       (out_valid && out_ready),
        .pop_data  (fifo_data),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign out_valid = !fifo_empty;
    assign count     = fifo_count + {{(CW-1){1'b0}}, stage_valid_q};

    always_comb begin
        out_sum   = '0;
        out_carry = 1'b0;
        out_ovf   = 1'b0;
        if (!fifo_empty) begin
            {out_ovf, out_carry, out_sum} = fifo_data;
        end
    end

endmodule

// File: tb/tb_pipe_adder.sv
// Self-checking bench for pipe_adder: queue-based reference model plus directed corner cases.
module tb_pipe_adder;

    localparam int W = 32;
    localparam int D = 4;

    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic [W-1:0]  in_a = '0;
    logic [W-1:0]  in_b = '0;
    logic          in_op = 1'b0;
    logic          in_valid = 1'b0;
    logic          out_ready = 1'b0;
    logic          in_ready;
    logic [W-1:0]  out_sum;
    logic          out_carry;
    logic          out_ovf;
    logic          out_valid;
    logic [2:0]    count;
    logic          sat_w;

`ifdef PIPE_ADDER_SAT_EN
    logic in_sat = 1'b0;
    assign sat_w = in_sat;
`else
    assign sat_w = 1'b0;
`endif

    always #5 clk = ~clk;

    pipe_adder #(
        .WIDTH (W),
        .DEPTH (D)
    ) dut (
        .clk       (clk),
        .resetn    (resetn),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_op     (in_op),
        .in_valid  (in_valid),
`ifdef PIPE_ADDER_SAT_EN
        .in_sat    (in_sat),
`endif
        .in_ready  (in_ready),
        .out_sum   (out_sum),
        .out_carry (out_carry),
        .out_ovf   (out_ovf),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .count     (count)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference arithmetic from signed/unsigned integer rules: {ovf, carry, sum}.
    function automatic logic [33:0] calc(input logic [31:0] a, input logic [31:0] b,
                                         input logic op, input logic sat);
        longint    sa, sb, r;
        logic [32:0] u;
        logic      carry, ovf;
        logic [31:0] s;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (op) begin
            r = sa - sb;
            carry = (a >= b);
            s = a - b;
        end else begin
            r = sa + sb;
            u = {1'b0, a} + {1'b0, b};
            carry = u[32];
            s = u[31:0];
        end
        ovf = (r > 64'sd2147483647) || (r < -64'sd2147483648);
        if (sat && ovf) s = (r > 0) ? 32'h7FFF_FFFF : 32'h8000_0000;
        return {ovf, carry, s};
    endfunction

    typedef struct {
        logic [33:0] res;
        int          vis;
    } ent_t;

    ent_t q[$];
    bit   run_m = 1'b0;
    bit   chk_en = 1'b0;
    int   cyc = 0;
    int   max_cnt = 0;
    int   n_deliv = 0;

    // Model: outstanding results in acceptance order; each becomes visible 2 cycles after accept.
    always @(negedge clk) begin : model
        logic        exp_valid;
        logic        exp_ready;
        logic [33:0] head;
        exp_valid = 1'b0;
        head = '0;
        if (q.size() > 0) begin
            if (cyc >= q[0].vis) begin
                exp_valid = 1'b1;
                head = q[0].res;
            end
        end
        exp_ready = run_m && (q.size() < D);
        if (chk_en) begin
            chk("out_valid", out_valid, exp_valid);
            chk("in_ready", in_ready, exp_ready);
            chk("count", count, q.size());
            chk("result", {out_ovf, out_carry, out_sum}, head);
            if (int'(count) > max_cnt) max_cnt = int'(count);
        end
        if (!resetn) begin
            q.delete();
            run_m = 1'b0;
            chk_en = 1'b1;
        end else begin
            if (exp_valid && out_ready) begin
                void'(q.pop_front());
                n_deliv++;
            end
            if (in_valid && exp_ready) begin
                q.push_back('{res: calc(in_a, in_b, in_op, sat_w), vis: cyc + 2});
            end
            run_m = 1'b1;
        end
        cyc++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_out(output logic [33:0] r);
        for (int k = 0; k < 20 && !out_valid; k++) step();
        chk("wait_out_valid", out_valid, 1);
        r = {out_ovf, out_carry, out_sum};
    endtask

    task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic op,
                         output logic [33:0] r);
        in_a = a;
        in_b = b;
        in_op = op;
        in_valid = 1'b1;
        for (int k = 0; k < 20 && !in_ready; k++) step();
        chk("do_op_ready", in_ready, 1);
        step();
        in_valid = 1'b0;
        wait_out(r);
        step();
    endtask

    function automatic logic [31:0] pick();
        logic [31:0] c [6];
        c[0] = 32'h0; c[1] = 32'h1; c[2] = 32'h7FFF_FFFF;
        c[3] = 32'h8000_0000; c[4] = 32'hFFFF_FFFF; c[5] = 32'h8000_0001;
        if ($urandom_range(0, 3) == 0) return c[$urandom_range(0, 5)];
        return $urandom;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish, expected $finish");
        $fatal(1);
    end

    initial begin
        logic [33:0] r;
        int idx, acc, d0, k;
        bit rdy;

        // Model pinned to hand-computed values.
        chk("model_5p7", calc(32'd5, 32'd7, 1'b0, 1'b0), {2'b00, 32'd12});
        chk("model_3m5", calc(32'd3, 32'd5, 1'b1, 1'b0), {2'b00, 32'hFFFF_FFFE});
        chk("model_max_p1", calc(32'h7FFF_FFFF, 32'd1, 1'b0, 1'b0), {2'b10, 32'h8000_0000});
        chk("model_sat_min", calc(32'h8000_0000, 32'd1, 1'b1, 1'b1), {2'b11, 32'h8000_0000});

        out_ready = 1'b1;
        repeat (3) step();
        resetn = 1'b1;
        chk("in_ready_idle", in_ready, 0);
        step();
        chk("in_ready_rise", in_ready, 1);

        // 5+7 with exact latency.
        in_a = 32'd5; in_b = 32'd7; in_op = 1'b0; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        chk("lat1_valid", out_valid, 0);
        step();
        chk("lat2_valid", out_valid, 1);
        chk("add_5_7", {out_ovf, out_carry, out_sum}, {2'b00, 32'd12});
        step();

        do_op(32'd3, 32'd5, 1'b1, r);
        chk("sub_3_5", r, {2'b00, 32'hFFFF_FFFE});
        do_op(32'h7FFF_FFFF, 32'd1, 1'b0, r);
        chk("add_ovf", r, {2'b10, 32'h8000_0000});
        do_op(32'hFFFF_FFFF, 32'd1, 1'b0, r);
        chk("add_carry", r, {2'b01, 32'h0});

        // Fill with out_ready low: only DEPTH ops fit.
        out_ready = 1'b0;
        idx = 0;
        for (int c = 0; c < 10; c++) begin
            in_valid = 1'b1; in_a = 32'd100 + idx; in_b = idx; in_op = 1'b0;
            rdy = in_ready;
            step();
            if (rdy) idx++;
        end
        chk("full_accepted", idx, 4);
        chk("full_count", count, 4);
        chk("full_in_ready", in_ready, 0);
        out_ready = 1'b1;
        d0 = n_deliv;
        for (k = 0; k < 30 && idx < 6; k++) begin
            in_a = 32'd100 + idx; in_b = idx;
            rdy = in_ready;
            step();
            if (rdy) idx++;
        end
        in_valid = 1'b0;
        for (k = 0; k < 20 && count != 0; k++) step();
        chk("drain_accepted", idx, 6);
        chk("drain_delivered", n_deliv - d0, 6);

        // Back-to-back burst.
        max_cnt = 0;
        d0 = n_deliv;
        for (int c = 0; c < 100; c++) begin
            in_valid = 1'b1; in_a = pick(); in_b = pick(); in_op = 1'($urandom_range(0, 1));
            chk("burst_ready", in_ready, 1);
            step();
        end
        in_valid = 1'b0;
        repeat (3) step();
        chk("burst_delivered", n_deliv - d0, 100);
        chk("burst_max_count", max_cnt <= 2, 1);

        // Random traffic with back-pressure.
        for (int c = 0; c < 400; c++) begin
            in_valid = 1'($urandom_range(0, 1));
            out_ready = ($urandom_range(0, 3) != 0);
            in_a = pick(); in_b = pick(); in_op = 1'($urandom_range(0, 1));
`ifdef PIPE_ADDER_SAT_EN
            in_sat = 1'($urandom_range(0, 1));
`endif
            step();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
`ifdef PIPE_ADDER_SAT_EN
        in_sat = 1'b0;
`endif
        for (k = 0; k < 20 && count != 0; k++) step();
        chk("random_drained", count, 0);

        // Reset with stored results.
        out_ready = 1'b0;
        acc = 0;
        for (k = 0; k < 20 && acc < 3; k++) begin
            in_valid = 1'b1; in_a = 32'd1000 + acc; in_b = 32'd1; in_op = 1'b0;
            rdy = in_ready;
            step();
            if (rdy) acc++;
        end
        in_valid = 1'b0;
        repeat (3) step();
        chk("pre_reset_count", count, 3);
        resetn = 1'b0;
        step();
        chk("reset_out_valid", out_valid, 0);
        chk("reset_count", count, 0);
        chk("reset_in_ready", in_ready, 0);
        resetn = 1'b1;
        step();
        out_ready = 1'b1;
        do_op(32'd1, 32'd1, 1'b0, r);
        chk("post_reset_first", r, {2'b00, 32'd2});

`ifdef PIPE_ADDER_SAT_EN
        in_sat = 1'b1;
        do_op(32'h7FFF_FFFF, 32'd1, 1'b0, r);
        chk("sat_pos", r, {2'b10, 32'h7FFF_FFFF});
        do_op(32'h8000_0000, 32'd1, 1'b1, r);
        chk("sat_neg", r, {2'b11, 32'h8000_0000});
        in_sat = 1'b0;
`endif

        repeat (3) step();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
